// File: rtl/kyber_b2b_pkg.sv
// rtl/kyber_b2b_pkg.sv - shared types and width helpers for the bits-to-bytes scheduler
// Holds the scheduler state encoding and the index/owner width helpers.
// The helpers return at least 1 so that a single-byte job or a single requester
// still produces a legal vector width.
package kyber_b2b_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } b2b_state_e;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Width of out_idx for a job of bit_length bits.
    function automatic int idx_w(input int bit_length);
        return clog2_min1(bit_length / 8);
    endfunction

    // Width of out_owner for num_req requesters.
    function automatic int own_w(input int num_req);
        return clog2_min1(num_req);
    endfunction

    // Widths for the default 1024-bit, two-requester configuration.
    localparam int IDX_W = idx_w(1024);
    localparam int OWN_W = own_w(2);

endpackage

// File: rtl/bits_to_bytes.sv
// rtl/bits_to_bytes.sv - combinational BitsToBytes converter (LSB-first)
// Splits a BIT_LENGTH-bit vector into BIT_LENGTH/8 bytes.
// Byte i, bit j is taken from input bit 8*i+j.
// Ports:
//   i_bits   in   BIT_LENGTH            bit vector
//   o_bytes  out  BYTE_LENGTH x 8       byte array, o_bytes[0] is the first byte
module bits_to_bytes #(
    parameter  int BIT_LENGTH  = 1024,
    localparam int BYTE_LENGTH = BIT_LENGTH / 8
) (
    input  logic [BIT_LENGTH-1:0]       i_bits,
    output logic [BYTE_LENGTH-1:0][7:0] o_bytes
);

    generate
        if ((BIT_LENGTH % 8) != 0) begin : g_len_check
            $error("bits_to_bytes: BIT_LENGTH must be a multiple of 8");
        end
    endgenerate

    always_comb begin
        o_bytes = '0;
        for (int i = 0; i < BYTE_LENGTH; i++) begin
            for (int j = 0; j < 8; j++) begin
                o_bytes[i][j] = i_bits[8*i + j];
            end
        end
    end

endmodule

// File: rtl/bits_to_bytes_sched.sv
// rtl/bits_to_bytes_sched.sv - round-robin scheduler sharing one BitsToBytes datapath
// Grants one requester at a time (round-robin from rr_ptr), captures its bit vector
// and streams it out one byte per accepted beat.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   abort                   synchronous job cancel, overrides everything
//   req_valid/req_ready     per-requester handshake, req_ready one-hot or zero
//   req_bits                per-requester bit vector
//   out_valid/out_ready     byte stream handshake
//   out_byte/out_idx        current byte and its index in the job
//   out_last                asserted on the final byte of the job
//   out_owner               requester that owns the current job
//   busy                    high whenever the FSM is not IDLE
module bits_to_bytes_sched
    import kyber_b2b_pkg::*;
#(
    parameter  int BIT_LENGTH  = 1024,
    parameter  int NUM_REQ     = 2,
    localparam int BYTE_LENGTH = BIT_LENGTH / 8,
    localparam int IDX_BITS    = idx_w(BIT_LENGTH),
    localparam int OWN_BITS    = own_w(NUM_REQ)
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               abort,
    input  logic [NUM_REQ-1:0]                 req_valid,
    output logic [NUM_REQ-1:0]                 req_ready,
    input  logic [NUM_REQ-1:0][BIT_LENGTH-1:0] req_bits,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [7:0]                         out_byte,
    output logic [IDX_BITS-1:0]                out_idx,
    output logic                               out_last,
    output logic [OWN_BITS-1:0]                out_owner,
    output logic                               busy
);

    localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(BYTE_LENGTH - 1);

    b2b_state_e                   r_state;
    b2b_state_e                   w_state_nxt;
    logic [BIT_LENGTH-1:0]        r_capture;
    logic [IDX_BITS-1:0]          r_idx;
    logic [OWN_BITS-1:0]          r_owner;
    logic [OWN_BITS-1:0]          r_rr_ptr;
    logic [OWN_BITS-1:0]          w_gnt;
    logic                         w_any;
    logic                         w_fire;
    logic                         w_beat;
    logic                         w_last;
    logic [BYTE_LENGTH-1:0][7:0]  w_bytes;

    // First asserted request scanning upward from ptr, wrapping at NUM_REQ.
    function automatic logic [OWN_BITS-1:0] rr_pick(
        input logic [NUM_REQ-1:0]  req,
        input logic [OWN_BITS-1:0] ptr
    );
        logic found;
        int   k;
        rr_pick = ptr;
        found   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            k = (int'(ptr) + i) % NUM_REQ;
            if (!found && req[k]) begin
                rr_pick = OWN_BITS'(k);
                found   = 1'b1;
            end
        end
    endfunction

    function automatic logic [OWN_BITS-1:0] next_ptr(input logic [OWN_BITS-1:0] g);
        return (g == OWN_BITS'(NUM_REQ - 1)) ? '0 : g + OWN_BITS'(1);
    endfunction

    bits_to_bytes #(
        .BIT_LENGTH (BIT_LENGTH)
    ) u_b2b (
        .i_bits  (r_capture),
        .o_bytes (w_bytes)
    );

    assign w_gnt  = rr_pick(req_valid, r_rr_ptr);
    assign w_any  = |req_valid;
    assign w_last = (r_idx == LAST_IDX);

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = '0;
        w_fire      = 1'b0;
        w_beat      = 1'b0;
        if (abort) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        req_ready[w_gnt] = 1'b1;
                        w_fire           = 1'b1;
                        w_state_nxt      = STREAM;
                    end
                end
                STREAM: begin
                    if (out_ready) begin
                        w_beat = 1'b1;
                        if (w_last) begin
                            w_state_nxt = IDLE;
                        end
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // An abort only clears the index; owner, capture and rr_ptr are left alone so
    // fairness continues from where it was.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_capture <= '0;
            r_idx     <= '0;
            r_owner   <= '0;
            r_rr_ptr  <= '0;
        end else if (abort) begin
            r_idx <= '0;
        end else if (w_fire) begin
            r_capture <= req_bits[w_gnt];
            r_owner   <= w_gnt;
            r_idx     <= '0;
            r_rr_ptr  <= next_ptr(w_gnt);
        end else if (w_beat && !w_last) begin
            r_idx <= r_idx + IDX_BITS'(1);
        end
    end

    assign out_valid = (r_state == STREAM);
    assign out_last  = out_valid && w_last;
    assign busy      = (r_state != IDLE);
    assign out_byte  = w_bytes[r_idx];
    assign out_idx   = r_idx;
    assign out_owner = r_owner;

endmodule

// File: tb/tb_bits_to_bytes_sched.sv
// tb/tb_bits_to_bytes_sched.sv - directed self-checking bench for bits_to_bytes_sched
module tb_bits_to_bytes_sched;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             abort = 1'b0;
    logic [1:0]       req_valid = 2'b00;
    logic [1:0]       req_ready;
    logic [1:0][31:0] req_bits = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [7:0]       out_byte;
    logic [1:0]       out_idx;
    logic             out_last;
    logic             out_owner;
    logic             busy;

    int         errors = 0;
    int         checks = 0;
    logic [1:0] pend = 2'b00;
    logic [7:0] exp3 [4];
    int         cnt;

    always #5 clk = ~clk;

    bits_to_bytes_sched #(
        .BIT_LENGTH (32),
        .NUM_REQ    (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .abort     (abort),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_bits  (req_bits),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_byte  (out_byte),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .out_owner (out_owner),
        .busy      (busy)
    );

    // Requester protocol: a pending request may not be withdrawn before acceptance.
    always @(negedge clk) begin
        if (!rst_n) begin
            pend = 2'b00;
        end else begin
            if ((pend & ~req_valid) != 2'b00) begin
                errors++;
                $display("FAIL req_valid_drop: observed=%b pending=%b", req_valid, pend);
            end
            pend = req_valid & ~req_ready;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input string t, input logic [7:0] b, input int idx, input logic own);
        chk({t, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({t, "_byte"},  {24'd0, out_byte}, {24'd0, b});
        chk({t, "_idx"},   {30'd0, out_idx}, idx);
        chk({t, "_last"},  {31'd0, out_last}, (idx == 3) ? 32'd1 : 32'd0);
        chk({t, "_owner"}, {31'd0, out_owner}, {31'd0, own});
        chk({t, "_rdy"},   {30'd0, req_ready}, 32'd0);
        tick();
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        // Reset values
        #2;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_ready", {30'd0, req_ready}, 32'd0);
        chk("rst_busy",  {31'd0, busy}, 32'd0);
        chk("rst_last",  {31'd0, out_last}, 32'd0);
        chk("rst_byte",  {24'd0, out_byte}, 32'd0);
        chk("rst_idx",   {30'd0, out_idx}, 32'd0);
        chk("rst_owner", {31'd0, out_owner}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;

        // 1: single job, LSB-first bytes
        req_bits[0] = 32'hA1B2C3D4;
        req_valid   = 2'b01;
        out_ready   = 1'b1;
        #1;
        chk("t1_grant", {30'd0, req_ready}, 32'h1);
        tick();
        req_valid = 2'b00;
        chk("t1_busy", {31'd0, busy}, 32'd1);
        beat("t1b0", 8'hD4, 0, 1'b0);
        beat("t1b1", 8'hC3, 1, 1'b0);
        beat("t1b2", 8'hB2, 2, 1'b0);
        beat("t1b3", 8'hA1, 3, 1'b0);
        chk("t1_end_valid", {31'd0, out_valid}, 32'd0);
        chk("t1_end_busy",  {31'd0, busy}, 32'd0);

        // 2: both requesting continuously -> 0,1,0 with one idle cycle between jobs
        do_reset();
        req_bits[0] = 32'h11111111;
        req_bits[1] = 32'h22222222;
        req_valid   = 2'b11;
        #1;
        chk("t2_grant0", {30'd0, req_ready}, 32'h1);
        tick();
        beat("t2j0b0", 8'h11, 0, 1'b0);
        beat("t2j0b1", 8'h11, 1, 1'b0);
        beat("t2j0b2", 8'h11, 2, 1'b0);
        beat("t2j0b3", 8'h11, 3, 1'b0);
        chk("t2_idle1_valid", {31'd0, out_valid}, 32'd0);
        chk("t2_grant1", {30'd0, req_ready}, 32'h2);
        tick();
        beat("t2j1b0", 8'h22, 0, 1'b1);
        beat("t2j1b1", 8'h22, 1, 1'b1);
        beat("t2j1b2", 8'h22, 2, 1'b1);
        beat("t2j1b3", 8'h22, 3, 1'b1);
        chk("t2_idle2_valid", {31'd0, out_valid}, 32'd0);
        chk("t2_grant0b", {30'd0, req_ready}, 32'h1);
        tick();
        req_valid = 2'b10;
        beat("t2j2b0", 8'h11, 0, 1'b0);
        beat("t2j2b1", 8'h11, 1, 1'b0);
        beat("t2j2b2", 8'h11, 2, 1'b0);
        beat("t2j2b3", 8'h11, 3, 1'b0);
        chk("t2_grant1b", {30'd0, req_ready}, 32'h2);
        tick();
        req_valid = 2'b00;
        beat("t2j3b0", 8'h22, 0, 1'b1);
        beat("t2j3b1", 8'h22, 1, 1'b1);
        beat("t2j3b2", 8'h22, 2, 1'b1);
        beat("t2j3b3", 8'h22, 3, 1'b1);

        // 3: out_ready stalls, bytes held and none skipped or repeated
        exp3[0] = 8'h11;
        exp3[1] = 8'h22;
        exp3[2] = 8'h33;
        exp3[3] = 8'h44;
        req_bits[0] = 32'h44332211;
        req_valid   = 2'b01;
        out_ready   = 1'b0;
        #1;
        chk("t3_grant", {30'd0, req_ready}, 32'h1);
        tick();
        req_valid = 2'b00;
        cnt = 0;
        for (int c = 0; c < 20 && cnt < 4; c++) begin
            out_ready = (c % 3 == 0);
            #1;
            chk("t3_valid", {31'd0, out_valid}, 32'd1);
            chk("t3_byte",  {24'd0, out_byte}, {24'd0, exp3[cnt]});
            chk("t3_idx",   {30'd0, out_idx}, cnt);
            if (out_ready) cnt++;
            tick();
        end
        out_ready = 1'b1;
        chk("t3_count", cnt, 32'd4);
        chk("t3_end_valid", {31'd0, out_valid}, 32'd0);

        // 4: abort mid-job, then abort while idle
        req_bits[1] = 32'hDEADBEEF;
        req_valid   = 2'b10;
        #1;
        chk("t4_grant", {30'd0, req_ready}, 32'h2);
        tick();
        req_valid = 2'b00;
        beat("t4b0", 8'hEF, 0, 1'b1);
        beat("t4b1", 8'hBE, 1, 1'b1);
        chk("t4_byte2", {24'd0, out_byte}, 32'hAD);
        abort       = 1'b1;
        req_bits[0] = 32'hCAFEF00D;
        req_valid   = 2'b01;
        #1;
        chk("t4_rdy_abort", {30'd0, req_ready}, 32'd0);
        tick();
        abort = 1'b0;
        #1;
        chk("t4_post_valid", {31'd0, out_valid}, 32'd0);
        chk("t4_post_busy",  {31'd0, busy}, 32'd0);
        chk("t4_post_idx",   {30'd0, out_idx}, 32'd0);
        chk("t4_post_rdy",   {30'd0, req_ready}, 32'h1);
        abort = 1'b1;
        #1;
        chk("t4_idle_abort_rdy", {30'd0, req_ready}, 32'd0);
        tick();
        abort = 1'b0;
        #1;
        chk("t4_idle_abort_valid", {31'd0, out_valid}, 32'd0);
        chk("t4_regrant", {30'd0, req_ready}, 32'h1);
        tick();
        req_valid = 2'b00;
        beat("t4nb0", 8'h0D, 0, 1'b0);
        beat("t4nb1", 8'hF0, 1, 1'b0);

        // 5: asynchronous reset mid-stream
        chk("t5_pre_idx", {30'd0, out_idx}, 32'd2);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t5_valid", {31'd0, out_valid}, 32'd0);
        chk("t5_busy",  {31'd0, busy}, 32'd0);
        chk("t5_idx",   {30'd0, out_idx}, 32'd0);
        chk("t5_byte",  {24'd0, out_byte}, 32'd0);
        chk("t5_owner", {31'd0, out_owner}, 32'd0);
        chk("t5_rdy",   {30'd0, req_ready}, 32'd0);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 6: priority back at requester 0, LSB-first with a single set bit
        req_bits[0] = 32'h00000080;
        req_bits[1] = 32'h55AA0FF0;
        req_valid   = 2'b11;
        #1;
        chk("t5_prio", {30'd0, req_ready}, 32'h1);
        tick();
        req_valid = 2'b10;
        beat("t6b0", 8'h80, 0, 1'b0);
        beat("t6b1", 8'h00, 1, 1'b0);
        beat("t6b2", 8'h00, 2, 1'b0);
        beat("t6b3", 8'h00, 3, 1'b0);
        chk("t6_grant1", {30'd0, req_ready}, 32'h2);
        tick();
        req_valid = 2'b00;
        beat("t6r1b0", 8'hF0, 0, 1'b1);
        beat("t6r1b1", 8'h0F, 1, 1'b1);
        beat("t6r1b2", 8'hAA, 2, 1'b1);
        beat("t6r1b3", 8'h55, 3, 1'b1);
        chk("t6_end_valid", {31'd0, out_valid}, 32'd0);
        chk("t6_end_busy",  {31'd0, busy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
